// File: rtl/alu_cmd_driver_pkg.sv
// ============================================================================
// Package : alu_cmd_driver_pkg
// Purpose : Shared types for the simple_alu command driver. Defines the ALU
//           opcode, the command/response records, the opcode used to park
//           the ALU between operations, and the driver FSM state encoding.
// Contents: opcode, alu_cmd_t, alu_rsp_t, ALU_PARK_OP, drv_state_e,
//           cmd_is_error()
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package alu_cmd_driver_pkg;

  localparam int ALU_DATA_W = 32;

  // Encoding 3'd7 is deliberately left unnamed; it is treated as illegal.
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    MOD = 3'd4,
    ACC = 3'd5,
    MAC = 3'd6
  } opcode;

  typedef struct packed {
    opcode                 op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic                  err;
  } alu_rsp_t;

  // ACC with a_reg == 0 leaves the accumulator untouched.
  localparam opcode ALU_PARK_OP = ACC;

  typedef enum logic [2:0] {
    ST_INIT0 = 3'd0,
    ST_INIT1 = 3'd1,
    ST_IDLE  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_CAPT  = 3'd4
  } drv_state_e;

  // A command errors when it divides by zero or carries an unnamed opcode.
  function automatic logic cmd_is_error(input opcode op, input logic [ALU_DATA_W-1:0] b);
    logic err;
    err = 1'b0;
    case (op)
      ADD, SUB, MUL, ACC, MAC: err = 1'b0;
      DIV, MOD:                err = (b == '0);
      default:                 err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
// ============================================================================
// Module  : alu_rsp_fifo
// Purpose : Shift-register response FIFO. Entry 0 is always the head, so the
//           head data and valid flag come straight from flops.
// Ports   : clock, reset_n     clock / async active-low reset
//           push_i, push_data_i write one response (never while full)
//           pop_i              remove the head (only while valid)
//           valid_o, head_o    head response and its valid flag
//           count_o            number of stored entries
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rsp_fifo
  import alu_cmd_driver_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  alu_rsp_t         push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output alu_rsp_t         head_o,
  output logic [CNT_W-1:0] count_o
);

  alu_rsp_t         mem_q [DEPTH];
  alu_rsp_t         mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             valid_q;

  // On a simultaneous pop the queue shifts down first, so the new entry
  // lands one slot lower than the current count.
  assign wr_idx  = pop_i ? (count_q - 1'b1) : count_q;
  assign count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);

  for (genvar g_i = 0; g_i < DEPTH; g_i++) begin : g_slot
    if (g_i == DEPTH - 1) begin : g_last
      assign mem_d[g_i] = (push_i && (wr_idx == CNT_W'(g_i))) ? push_data_i :
                          pop_i                               ? '0          :
                                                                mem_q[g_i];
    end else begin : g_mid
      assign mem_d[g_i] = (push_i && (wr_idx == CNT_W'(g_i))) ? push_data_i   :
                          pop_i                               ? mem_q[g_i+1]  :
                                                                mem_q[g_i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign valid_o = valid_q;
  assign head_o  = mem_q[0];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/alu_cmd_driver.sv
// ============================================================================
// Module  : alu_cmd_driver
// Purpose : Initiator for simple_alu. Accepts {op,a,b} commands, sequences
//           the ALU so each op executes exactly once, and returns {data,err}
//           through a response FIFO. Between ops the ALU is parked
//           (a_reg=b_reg=0, mode=ACC) so its accumulator persists.
// Ports   : clock, reset_n                 clock / async active-low reset
//           cmd_valid/ready, cmd_op/a/b    command channel
//           rsp_valid/ready, rsp_data/err  response channel
//           alu_start/a/b/mode, alu_c      simple_alu interface
// Note    : DATA_W must equal ALU_DATA_W (32) to match simple_alu.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_driver
  import alu_cmd_driver_pkg::*;
#(
  parameter int DATA_W    = ALU_DATA_W,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  opcode             cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              alu_start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output opcode             alu_mode,
  input  logic [DATA_W-1:0] alu_c
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  drv_state_e       state_q;
  opcode            mode_q;
  logic             err_q;

  alu_cmd_t         cmd;
  logic             cmd_err;
  logic             can_issue;
  logic             accept;
  logic [CNT_W:0]   occupancy;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  alu_rsp_t         push_rsp;
  alu_rsp_t         head_rsp;

  assign cmd     = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_err = cmd_is_error(cmd.op, cmd.b);

  // CAPT pushes on the coming edge, so its slot is reserved here. A pop in
  // the same cycle is not credited, keeping cmd_ready independent of rsp_ready.
  assign can_issue = (state_q == ST_IDLE) || (state_q == ST_CAPT);
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (state_q == ST_CAPT)};
  assign cmd_ready = can_issue && (occupancy < (CNT_W+1)'(RSP_DEPTH));
  assign accept    = cmd_valid && cmd_ready;

  // Operands load on the accept edge while mode is still ACC with a_reg=0,
  // so the accumulator is unchanged until EXEC. Error commands load zeros.
  assign alu_start = 1'b1;
  assign alu_a     = (accept && !cmd_err) ? cmd.a : '0;
  assign alu_b     = (accept && !cmd_err) ? cmd.b : '0;
  assign alu_mode  = mode_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT0;
      mode_q  <= ADD;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        // ADD with zero operands: INIT0 clears a_reg/b_reg, INIT1 clears acc.
        ST_INIT0: begin
          state_q <= ST_INIT1;
          mode_q  <= ADD;
        end
        ST_INIT1: begin
          state_q <= ST_IDLE;
          mode_q  <= ALU_PARK_OP;
        end
        ST_IDLE, ST_CAPT: begin
          if (accept) begin
            state_q <= ST_EXEC;
            err_q   <= cmd_err;
            mode_q  <= cmd_err ? ALU_PARK_OP : cmd.op;
          end else begin
            state_q <= ST_IDLE;
            mode_q  <= ALU_PARK_OP;
          end
        end
        ST_EXEC: begin
          state_q <= ST_CAPT;
          mode_q  <= ALU_PARK_OP;
        end
        default: begin
          state_q <= ST_INIT0;
          mode_q  <= ADD;
        end
      endcase
    end
  end

  assign fifo_push = (state_q == ST_CAPT);
  assign push_rsp  = '{data: (err_q ? '0 : alu_c), err: err_q};
  assign fifo_pop  = rsp_valid && rsp_ready;

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i (push_rsp),
    .pop_i       (fifo_pop),
    .valid_o     (rsp_valid),
    .head_o      (head_rsp),
    .count_o     (fifo_count)
  );

  assign rsp_data = head_rsp.data;
  assign rsp_err  = head_rsp.err;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
// ============================================================================
// Module  : tb_alu_cmd_driver
// Purpose : Self-checking bench for alu_cmd_driver with a behavioural
//           simple_alu attached. Directed vectors with hand-computed results
//           plus sequences for back-pressure and reset mid-operation.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_driver;
  import alu_cmd_driver_pkg::*;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  opcode         cmd_op = ADD;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          alu_start;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  opcode         alu_mode;
  logic [DW-1:0] alu_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  alu_cmd_driver #(.DATA_W(DW), .RSP_DEPTH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_start (alu_start),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_c     (alu_c)
  );

  // Behavioural simple_alu: operands load on start, result and accumulator
  // update every edge; operand registers have no reset.
  logic [DW-1:0] m_a_reg, m_b_reg, m_acc, m_res;
  logic [DW-1:0] m_f;
  always_comb begin
    m_f = m_acc;
    case (alu_mode)
      ADD: m_f = m_a_reg + m_b_reg;
      SUB: m_f = m_a_reg - m_b_reg;
      MUL: m_f = m_a_reg * m_b_reg;
      DIV: m_f = (m_b_reg == '0) ? '0 : m_a_reg / m_b_reg;
      MOD: m_f = (m_b_reg == '0) ? '0 : m_a_reg % m_b_reg;
      ACC: m_f = m_acc + m_a_reg;
      MAC: m_f = m_acc + m_a_reg * m_b_reg;
      default: m_f = m_acc;
    endcase
  end
  always @(posedge clock) begin
    if (alu_start) begin
      m_a_reg <= alu_a;
      m_b_reg <= alu_b;
    end
    m_res <= m_f;
    m_acc <= m_f;
  end
  assign alu_c = m_res;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // Offer one command and return one step after the accepting edge.
  task automatic send(input opcode op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!cmd_ready) timeout_fail("cmd_accept");
    else begin
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, compare it, then pop it.
  task automatic get_rsp(input string name, input logic [DW-1:0] exp_d, input logic exp_e,
                         output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clock); #1; lat++;
    end
    if (!rsp_valid) timeout_fail({name, "_wait"});
    else begin
      check({name, "_data"}, rsp_data, exp_d);
      check({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    opcode         op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    logic          exp_err;
    int            idle;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    int lat;
    int accepted;
    logic take;

    vecs[0]  = '{ADD, 32'd5,       32'd7,       32'd12,         1'b0, 0};
    vecs[1]  = '{ADD, 32'd0,       32'd0,       32'd0,          1'b0, 0};
    vecs[2]  = '{ACC, 32'd10,      32'd0,       32'd10,         1'b0, 0};
    vecs[3]  = '{ACC, 32'd5,       32'd0,       32'd15,         1'b0, 20};
    vecs[4]  = '{ADD, 32'd2,       32'd3,       32'd5,          1'b0, 0};
    vecs[5]  = '{MAC, 32'd4,       32'd6,       32'd29,         1'b0, 0};
    vecs[6]  = '{SUB, 32'd3,       32'd5,       32'hFFFF_FFFE,  1'b0, 0};
    vecs[7]  = '{MUL, 32'h1_0000,  32'h1_0000,  32'd0,          1'b0, 0};
    vecs[8]  = '{ADD, 32'd0,       32'd0,       32'd0,          1'b0, 0};
    vecs[9]  = '{ACC, 32'd7,       32'd0,       32'd7,          1'b0, 0};
    vecs[10] = '{DIV, 32'd100,     32'd0,       32'd0,          1'b1, 0};
    vecs[11] = '{MOD, 32'd17,      32'd5,       32'd2,          1'b0, 0};
    vecs[12] = '{ACC, 32'd1,       32'd0,       32'd3,          1'b0, 0};
    vecs[13] = '{opcode'(3'd7), 32'd9, 32'd9,   32'd0,          1'b1, 0};
    vecs[14] = '{ACC, 32'd0,       32'd0,       32'd3,          1'b0, 3};
    vecs[15] = '{MOD, 32'd5,       32'd0,       32'd0,          1'b1, 0};
    vecs[16] = '{DIV, 32'd40,      32'd8,       32'd5,          1'b0, 0};

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_alu_start", {31'd0, alu_start}, 32'd1);
    check("rst_alu_a",     alu_a, 32'd0);
    check("rst_alu_b",     alu_b, 32'd0);
    check("rst_alu_mode",  {29'd0, alu_mode}, {29'd0, ADD});

    // INIT0 -> INIT1 -> IDLE after release
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("init1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("init1_mode",      {29'd0, alu_mode}, {29'd0, ADD});
    @(posedge clock); #1;
    check("idle_cmd_ready",  {31'd0, cmd_ready}, 32'd1);
    check("idle_mode",       {29'd0, alu_mode}, {29'd0, ACC});

    // Directed vector table; accumulator state carries from entry to entry.
    for (int i = 0; i < NV; i++) begin
      repeat (vecs[i].idle) @(posedge clock);
      #1;
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      get_rsp($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_err, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd2);
    end

    // Back-pressure: 6 ADD k,100 offered with rsp_ready low; only 4 fit.
    accepted = 0;
    cmd_valid = 1'b1; cmd_op = ADD; cmd_a = 32'd1; cmd_b = 32'd100;
    for (int c = 0; c < 24; c++) begin
      take = cmd_valid && cmd_ready;
      @(posedge clock); #1;
      if (take) begin
        accepted++;
        cmd_a = accepted + 1;
        if (accepted == 6) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("bp_accepted",  accepted, 32'd4);
    check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int k = 1; k <= 4; k++)
      get_rsp($sformatf("bp_rsp%0d", k), 32'd100 + k, 1'b0, lat);
    check("bp_drained_ready", {31'd0, cmd_ready}, 32'd1);
    for (int k = 5; k <= 6; k++) begin
      send(ADD, k, 32'd100);
      get_rsp($sformatf("bp_rsp%0d", k), 32'd100 + k, 1'b0, lat);
    end

    // Reset during EXEC of DIV 9,3: nothing comes out, INIT replays, acc=0.
    send(DIV, 32'd9, 32'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_mode",      {29'd0, alu_mode}, {29'd0, ADD});
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_init1_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clock); #1;
    check("mid_rst_idle_ready",  {31'd0, cmd_ready}, 32'd1);
    repeat (5) @(posedge clock);
    #1;
    check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(ACC, 32'd4, 32'd0);
    get_rsp("post_rst_acc", 32'd4, 1'b0, lat);
    check("post_rst_latency", lat, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
